// File: rtl/spi_flash_responder_if.sv
// Purpose: bundles the SPI pins and the byte-wide memory read port of the
//          flash responder.
// Ports (slave = the responder):
//   spi_cs_n, spi_sclk, spi_in0  in   SPI select, mode-0 clock, io[0]
//   spi_out[3:0], spi_oe[3:0]    out  io[3:0] values and drive enables
//   mem_rd, mem_addr             out  1-clk read strobe and byte address
//   mem_data                     in   read data, valid the clk after mem_rd
//   busy, cmd_err                out  selected flag, bad-opcode pulse
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_in0;
  logic [3:0]        spi_out;
  logic [3:0]        spi_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              busy;
  logic              cmd_err;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_in0, mem_data,
    output spi_out, spi_oe, mem_rd, mem_addr, busy, cmd_err
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_in0, mem_data,
    input  spi_out, spi_oe, mem_rd, mem_addr, busy, cmd_err
  );
endinterface

// File: rtl/spi_flash_responder.sv
// Purpose: SPI NOR-flash responder. Oversamples /CS, SCLK and io[0] on clk,
//          decodes READ (0x03), FAST READ (0x0B) and QUAD OUTPUT FAST READ
//          (0x6B), and streams bytes fetched from a synchronous memory port.
// Ports:
//   clk    in  system clock, at least 4x the SCLK frequency
//   reset  in  asynchronous, active-high reset
//   bus    spi_flash_responder_if.slave (SPI pins + memory read port)
module spi_flash_responder #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_flash_responder_if.slave  bus
);

  localparam int unsigned CNT_MAX = (DUMMY_CYCLES > 24) ? DUMMY_CYCLES : 24;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, in0_sync;
  logic                   sclk_d;
  logic [CNT_W-1:0]       cnt;
  logic [23:0]            shreg;
  logic                   use_dummy;
  logic                   quad;
  logic [2:0]             bit_idx;
  logic [7:0]             byte_q;
  logic                   ld;

  logic        cs_n_s, sclk_s, in0_s, sclk_rise, sclk_fall, last_unit;
  logic [23:0] shift_next;
  logic [7:0]  byte_now;

  assign cs_n_s     = cs_sync[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign in0_s      = in0_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign shift_next = {shreg[22:0], in0_s};
  // Bypass the holding register in the clk the fetched byte arrives, so a
  // fall landing right after the fetch still sees the new byte.
  assign byte_now   = ld ? bus.mem_data : byte_q;
  assign last_unit  = quad ? bit_idx[0] : (bit_idx == 3'd7);

  // Input synchronisers plus one extra SCLK flop for edge detection.
  // The select chain resets to deselected so reset release cannot start a command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      in0_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      in0_sync  <= {in0_sync[SYNC_STAGES-2:0], bus.spi_in0};
      sclk_d    <= sclk_s;
    end
  end

  // Protocol FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      use_dummy    <= 1'b0;
      quad         <= 1'b0;
      bit_idx      <= '0;
      byte_q       <= '0;
      ld           <= 1'b0;
      bus.spi_out  <= '0;
      bus.spi_oe   <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      bus.busy     <= 1'b0;
      bus.cmd_err  <= 1'b0;
    end else begin
      bus.mem_rd  <= 1'b0;
      bus.cmd_err <= 1'b0;
      ld          <= bus.mem_rd;
      if (ld) byte_q <= bus.mem_data;

      if (cs_n_s) begin
        // Deselect aborts whatever was in progress.
        state       <= S_IDLE;
        cnt         <= '0;
        bit_idx     <= '0;
        bus.spi_out <= '0;
        bus.spi_oe  <= '0;
        bus.busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_CMD;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end

          S_CMD: if (sclk_rise) begin
            shreg <= shift_next;
            if (cnt == CNT_W'(7)) begin
              cnt <= '0;
              case (shift_next[7:0])
                8'h03: begin state <= S_ADDR; use_dummy <= 1'b0; quad <= 1'b0; end
                8'h0B: begin state <= S_ADDR; use_dummy <= 1'b1; quad <= 1'b0; end
                8'h6B: begin state <= S_ADDR; use_dummy <= 1'b1; quad <= 1'b1; end
                default: begin
                  state       <= S_IGNORE;
                  bus.cmd_err <= 1'b1;
                end
              endcase
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_ADDR: if (sclk_rise) begin
            shreg <= shift_next;
            if (cnt == CNT_W'(23)) begin
              cnt          <= '0;
              bit_idx      <= '0;
              bus.mem_addr <= shift_next[ADDR_W-1:0];
              bus.mem_rd   <= 1'b1;
              if (use_dummy) begin
                state <= S_DUMMY;
              end else begin
                state      <= S_DATA;
                bus.spi_oe <= 4'b0010;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_DUMMY: if (sclk_rise) begin
            if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
              cnt   <= '0;
              state <= S_DATA;
              if (!quad) bus.spi_oe <= 4'b0010;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_DATA: if (sclk_fall) begin
            if (quad) begin
              bus.spi_oe  <= 4'b1111;
              bus.spi_out <= bit_idx[0] ? byte_now[3:0] : byte_now[7:4];
            end else begin
              bus.spi_out <= {2'b00, byte_now[3'd7 - bit_idx], 1'b0};
            end
            // Prefetch the next byte as the last unit of this one goes out.
            if (last_unit) begin
              bit_idx      <= '0;
              bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
              bus.mem_rd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end

          S_IGNORE: ;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Purpose: self-checking bench for spi_flash_responder. A driver acts as the
//          SPI initiator, a queue holds expected bytes from a reference memory
//          model, and a monitor assembles bytes on SCLK rises and compares.
module tb_spi_flash_responder;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DUMMY  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

  spi_flash_responder #(
    .ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         data_phase = 1'b0;
  bit         quad_mode  = 1'b0;
  int         err_seen = 0;
  int         err_exp  = 0;
  logic       prev_err = 1'b0;
  logic       prev_rd  = 1'b0;

  // Reference memory contents.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_data <= mem_byte(24'(bus.mem_addr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte monitor / scoreboard.
  initial begin : monitor
    logic [7:0] acc;
    int         nbits;
    acc   = '0;
    nbits = 0;
    forever begin
      @(posedge bus.spi_sclk or posedge bus.spi_cs_n);
      if (bus.spi_cs_n) begin
        nbits = 0;
        acc   = '0;
      end else begin
        chk("busy_selected", 32'(bus.busy), 32'd1);
        if (data_phase) begin
          if (quad_mode) begin
            chk("oe_quad", 32'(bus.spi_oe), 32'hF);
            acc   = {acc[3:0], bus.spi_out};
            nbits += 4;
          end else begin
            chk("oe_single", 32'(bus.spi_oe), 32'h2);
            acc   = {acc[6:0], bus.spi_out[1]};
            nbits += 1;
          end
          if (nbits == 8) begin
            nbits = 0;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_byte: got 0x%0h with empty scoreboard at %0t", acc, $time);
            end else begin
              chk("data_byte", 32'(acc), 32'(exp_q.pop_front()));
            end
          end
        end else begin
          chk("oe_not_data", 32'(bus.spi_oe), 32'h0);
        end
      end
    end
  end

  // Pulse-shape monitor for cmd_err and mem_rd.
  always @(negedge clk) begin
    if (bus.cmd_err === 1'b1) begin
      err_seen++;
      chk("cmd_err_single_pulse", 32'(prev_err), 32'd0);
    end
    if (bus.mem_rd === 1'b1) chk("mem_rd_not_back_to_back", 32'(prev_rd), 32'd0);
    prev_err = bus.cmd_err;
    prev_rd  = bus.mem_rd;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b);
    bus.spi_in0 = b;
    clk_wait(8);
    bus.spi_sclk = 1'b1;
    clk_wait(8);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_cycle(v[i]);
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    clk_wait(8);
  endtask

  // Deselect and confirm release within SYNC_STAGES+1 clks.
  task automatic cs_high();
    data_phase   = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_in0  = 1'b0;
    clk_wait(3);
    chk("busy_release", 32'(bus.busy), 32'd0);
    chk("oe_release", 32'(bus.spi_oe), 32'd0);
    chk("out_release", 32'(bus.spi_out), 32'd0);
    clk_wait(5);
  endtask

  task automatic do_read(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
    bit q;
    q = (op == 8'h6B);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(mem_byte(addr + 24'(i)));
    cs_low();
    send_bits(32'(op), 8);
    send_bits(32'(addr), 24);
    if (op != 8'h03) send_bits(32'd0, DUMMY);
    quad_mode  = q;
    data_phase = 1'b1;
    send_bits(32'd0, nbytes * (q ? 2 : 8));
    cs_high();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_bad(input logic [7:0] op);
    err_exp++;
    cs_low();
    send_bits(32'(op), 8);
    send_bits(32'($urandom), 16);
    cs_high();
    chk("cmd_err_count", 32'(err_seen), 32'(err_exp));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0] op;
    logic [7:0] ops[3];
    ops[0] = 8'h03;
    ops[1] = 8'h0B;
    ops[2] = 8'h6B;
    reset        = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_in0  = 1'b0;
    clk_wait(3);
    chk("rst_spi_out", 32'(bus.spi_out), 32'd0);
    chk("rst_spi_oe", 32'(bus.spi_oe), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    reset = 1'b0;
    clk_wait(3);

    do_read(8'h03, 24'h000010, 4);
    do_read(8'h0B, 24'h0000FE, 3);
    do_read(8'h6B, 24'h000020, 4);
    do_read(8'h0B, 24'hFFFFFE, 3);
    do_read(8'h6B, 24'hFFFFFF, 2);
    do_bad(8'h9F);

    // Deselect after 12 address bits, then a clean read.
    cs_low();
    send_bits(32'h03, 8);
    send_bits(32'h000, 12);
    cs_high();
    do_read(8'h03, 24'h000005, 1);

    // Reset in the middle of a quad data phase.
    exp_q.push_back(mem_byte(24'h000030));
    exp_q.push_back(mem_byte(24'h000031));
    cs_low();
    send_bits(32'h6B, 8);
    send_bits(32'h000030, 24);
    send_bits(32'd0, DUMMY);
    quad_mode  = 1'b1;
    data_phase = 1'b1;
    send_bits(32'd0, 5);
    clk_wait(4);
    chk("quad_oe_before_reset", 32'(bus.spi_oe), 32'hF);
    reset = 1'b1;
    #1;
    chk("midreset_oe", 32'(bus.spi_oe), 32'd0);
    chk("midreset_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_out", 32'(bus.spi_out), 32'd0);
    data_phase   = 1'b0;
    bus.spi_cs_n = 1'b1;
    clk_wait(4);
    reset = 1'b0;
    clk_wait(4);
    chk("scoreboard_drained_reset", 32'(exp_q.size()), 32'd0);
    do_read(8'h03, 24'h000040, 2);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 8'($urandom); while (op == 8'h03 || op == 8'h0B || op == 8'h6B);
        do_bad(op);
      end else begin
        do_read(ops[$urandom_range(0, 2)], 24'($urandom), int'($urandom_range(1, 4)));
      end
    end

    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_cmd_err_count", 32'(err_seen), 32'(err_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
